hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 90 +++++++++
 tb/tb_hazard_scoreboard.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard query/response bundle for hazard_scoreboard.
// The master drives the decoded instruction; the slave returns the hazard verdict.
interface hazard_scoreboard_if #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned MAX_LAT = 8
);
    localparam int unsigned IDX_W = $clog2(NREG);
    localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);
    localparam int unsigned CNT_W = $clog2(2 * NREG + 1);

    logic             freeze;
    logic             flush_d;
    logic             valid_d;
    logic [IDX_W-1:0] rs1_d;
    logic [IDX_W-1:0] rs2_d;
    logic [IDX_W-1:0] rs3_d;
    logic             use_rs1_d;
    logic             use_rs2_d;
    logic             use_rs3_d;
    logic             fp_rs1_d;
    logic             fp_rs2_d;
    logic             fp_rs3_d;
    logic [IDX_W-1:0] rd_d;
    logic             fp_rd_d;
    logic [LAT_W-1:0] wr_lat_d;
    logic             stall_d;
    logic             raw_hazard;
    logic             waw_hazard;
    logic [CNT_W-1:0] pending_cnt;

    modport master (
        output freeze, flush_d, valid_d,
        output rs1_d, rs2_d, rs3_d, use_rs1_d, use_rs2_d, use_rs3_d,
        output fp_rs1_d, fp_rs2_d, fp_rs3_d, rd_d, fp_rd_d, wr_lat_d,
        input  stall_d, raw_hazard, waw_hazard, pending_cnt
    );

    modport slave (
        input  freeze, flush_d, valid_d,
        input  rs1_d, rs2_d, rs3_d, use_rs1_d, use_rs2_d, use_rs3_d,
        input  fp_rs1_d, fp_rs2_d, fp_rs3_d, rd_d, fp_rd_d, wr_lat_d,
        output stall_d, raw_hazard, waw_hazard, pending_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/WAW scoreboard: one write-latency down-counter per integer and FP register.
// Define HAZARD_SCOREBOARD_FWD_EN to treat a source as ready one cycle early (write-back bypass).
module hazard_scoreboard #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned MAX_LAT = 8
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NREG);
    localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);
    localparam int unsigned CNT_W = $clog2(2 * NREG + 1);

    logic [LAT_W-1:0] int_q [NREG];
    logic [LAT_W-1:0] fp_q  [NREG];
    logic [LAT_W-1:0] int_d [NREG];
    logic [LAT_W-1:0] fp_d  [NREG];
    logic [CNT_W-1:0] pend_q;
    logic [CNT_W-1:0] pend_d;

    logic [LAT_W-1:0] c_rs1, c_rs2, c_rs3, c_rd, lat_sat;
    logic             rd_tracked, has_wr, raw, waw, stall, issue;

    // A source still waiting on its producer.
    function automatic logic busy(input logic [LAT_W-1:0] c);
`ifdef HAZARD_SCOREBOARD_FWD_EN
        return c > LAT_W'(1);
`else
        return c != '0;
`endif
    endfunction

    // Integer register 0 is never loaded, so its counter reads zero and never hazards.
    assign c_rs1 = bus.fp_rs1_d ? fp_q[bus.rs1_d] : int_q[bus.rs1_d];
    assign c_rs2 = bus.fp_rs2_d ? fp_q[bus.rs2_d] : int_q[bus.rs2_d];
    assign c_rs3 = bus.fp_rs3_d ? fp_q[bus.rs3_d] : int_q[bus.rs3_d];
    assign c_rd  = bus.fp_rd_d  ? fp_q[bus.rd_d]  : int_q[bus.rd_d];

    assign rd_tracked = bus.fp_rd_d | (bus.rd_d != '0);
    assign has_wr     = bus.wr_lat_d != '0;
    assign lat_sat    = (bus.wr_lat_d > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : bus.wr_lat_d;

    assign raw = bus.valid_d & ((bus.use_rs1_d & busy(c_rs1)) |
                                (bus.use_rs2_d & busy(c_rs2)) |
                                (bus.use_rs3_d & busy(c_rs3)));
    // Younger write may not land before an older one to the same register.
    assign waw   = bus.valid_d & has_wr & rd_tracked & (c_rd > bus.wr_lat_d);
    assign stall = raw | waw;
    assign issue = bus.valid_d & ~stall & ~bus.flush_d & ~bus.freeze & has_wr & rd_tracked;

    // Next counter state: age all counters, then the issue load overrides its target.
    always_comb begin
        pend_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            int_d[i] = int_q[i];
            fp_d[i]  = fp_q[i];
            if (!bus.freeze) begin
                if (int_q[i] != '0) int_d[i] = int_q[i] - LAT_W'(1);
                if (fp_q[i]  != '0) fp_d[i]  = fp_q[i]  - LAT_W'(1);
            end
            if (issue && (bus.rd_d == IDX_W'(i))) begin
                if (bus.fp_rd_d) fp_d[i]  = lat_sat;
                else             int_d[i] = lat_sat;
            end
            pend_d = pend_d + CNT_W'(int_d[i] != '0) + CNT_W'(fp_d[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                int_q[i] <= '0;
                fp_q[i]  <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                int_q[i] <= int_d[i];
                fp_q[i]  <= fp_d[i];
            end
            pend_q <= pend_d;
        end
    end

    assign bus.raw_hazard  = raw;
    assign bus.waw_hazard  = waw;
    assign bus.stall_d     = stall;
    assign bus.pending_cnt = pend_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard against a per-register "cycles until write-back" model.
// Build with +define+HAZARD_SCOREBOARD_FWD_EN to check the bypass variant.
module tb_hazard_scoreboard;
    localparam int unsigned NREG    = 32;
    localparam int unsigned MAX_LAT = 8;
    localparam int unsigned IDX_W   = $clog2(NREG);
    localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);

`ifdef HAZARD_SCOREBOARD_FWD_EN
    localparam int RDY_MAX = 1;
`else
    localparam int RDY_MAX = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(NREG), .MAX_LAT(MAX_LAT)) bus ();
    hazard_scoreboard #(.NREG(NREG), .MAX_LAT(MAX_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    // Cycles remaining until each register's pending result is written.
    int rem_i [NREG];
    int rem_f [NREG];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rem(input bit fp, input int idx);
        if (fp) return rem_f[idx];
        if (idx == 0) return 0;
        return rem_i[idx];
    endfunction

    function automatic bit waiting(input bit fp, input int idx);
        return rem(fp, idx) > RDY_MAX;
    endfunction

    function automatic int n_pending();
        int n = 0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (rem_i[i] != 0) n++;
            if (rem_f[i] != 0) n++;
        end
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(NREG); i++) begin
            rem_i[i] = 0;
            rem_f[i] = 0;
        end
    endtask

    task automatic idle();
        bus.freeze = 0; bus.flush_d = 0; bus.valid_d = 0;
        bus.rs1_d = '0; bus.rs2_d = '0; bus.rs3_d = '0;
        bus.use_rs1_d = 0; bus.use_rs2_d = 0; bus.use_rs3_d = 0;
        bus.fp_rs1_d = 0; bus.fp_rs2_d = 0; bus.fp_rs3_d = 0;
        bus.rd_d = '0; bus.fp_rd_d = 0; bus.wr_lat_d = '0;
    endtask

    task automatic put_write(input bit fp, input int rd, input int lat);
        idle();
        bus.valid_d = 1; bus.fp_rd_d = fp;
        bus.rd_d = IDX_W'(rd); bus.wr_lat_d = LAT_W'(lat);
    endtask

    // Called at posedge+1 with inputs set; checks hazards mid-cycle, then pending after the edge.
    task automatic cycle(output bit st);
        bit e_raw, e_waw, e_st, iss, trk;
        int lat, rd;
        #4;
        rd  = int'(bus.rd_d);
        lat = int'(bus.wr_lat_d);
        trk = bus.fp_rd_d || rd != 0;
        e_raw = bus.valid_d && ((bus.use_rs1_d && waiting(bus.fp_rs1_d, int'(bus.rs1_d))) ||
                                (bus.use_rs2_d && waiting(bus.fp_rs2_d, int'(bus.rs2_d))) ||
                                (bus.use_rs3_d && waiting(bus.fp_rs3_d, int'(bus.rs3_d))));
        e_waw = bus.valid_d && lat != 0 && trk && rem(bus.fp_rd_d, rd) > lat;
        e_st  = e_raw || e_waw;
        check("raw_hazard", 32'(bus.raw_hazard), 32'(e_raw));
        check("waw_hazard", 32'(bus.waw_hazard), 32'(e_waw));
        check("stall_d", 32'(bus.stall_d), 32'(e_st));
        st  = bus.stall_d;
        iss = bus.valid_d && !e_st && !bus.flush_d && !bus.freeze && lat != 0 && trk;
        if (lat > int'(MAX_LAT)) lat = MAX_LAT;
        @(posedge clk);
        if (!bus.freeze) begin
            for (int i = 0; i < int'(NREG); i++) begin
                if (rem_i[i] > 0) rem_i[i]--;
                if (rem_f[i] > 0) rem_f[i]--;
            end
        end
        if (iss) begin
            if (bus.fp_rd_d) rem_f[rd] = lat;
            else             rem_i[rd] = lat;
        end
        #1;
        check("pending_cnt", 32'(bus.pending_cnt), 32'(n_pending()));
    endtask

    task automatic run_idle(input int n);
        bit st;
        idle();
        for (int k = 0; k < n; k++) cycle(st);
    endtask

    // Asynchronous reset pulse in the middle of a cycle; outputs must clear immediately.
    task automatic pulse_reset();
        #2;
        rst = 1;
        #1;
        check("rst_stall", 32'(bus.stall_d), 32'd0);
        check("rst_raw", 32'(bus.raw_hazard), 32'd0);
        check("rst_waw", 32'(bus.waw_hazard), 32'd0);
        check("rst_pending", 32'(bus.pending_cnt), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        bit st;
        int cnt;
        model_clear();
        idle();
        rst = 1;
        bus.valid_d = 1; bus.use_rs1_d = 1; bus.rs1_d = IDX_W'(1);
        @(posedge clk);
        #1;
        check("reset_pending", 32'(bus.pending_cnt), 32'd0);
        check("reset_stall", 32'(bus.stall_d), 32'd0);
        rst = 0;
        run_idle(2);

        // RAW on an integer register: stall length depends on bypass.
        put_write(0, 5, 3); cycle(st);
        idle(); bus.valid_d = 1; bus.use_rs1_d = 1; bus.rs1_d = IDX_W'(5);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(st);
            if (!st) break;
            cnt++;
        end
        check("raw_stall_cycles", 32'(cnt), 32'(3 - RDY_MAX));
        run_idle(4);

        // Integer x0 is untracked; FP f0 is tracked.
        put_write(0, 0, 4); cycle(st);
        idle(); bus.valid_d = 1; bus.use_rs1_d = 1; cycle(st);
        put_write(1, 0, 4); cycle(st);
        idle(); bus.valid_d = 1; bus.use_rs1_d = 1; bus.fp_rs1_d = 1; cycle(st);
        check("fp0_stalls", 32'(st), 32'd1);
        run_idle(6);

        // WAW: a shorter write waits until the older one is no further out.
        put_write(1, 3, 6); cycle(st);
        put_write(1, 3, 2);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(st);
            if (!st) break;
            cnt++;
        end
        check("waw_cycles", 32'(cnt), 32'd4);
        run_idle(4);

        // Freeze holds counters, stretching the RAW stall by the freeze length.
        put_write(0, 7, 4); cycle(st);
        idle(); bus.valid_d = 1; bus.use_rs2_d = 1; bus.rs2_d = IDX_W'(7);
        bus.freeze = 1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(st);
            if (st) cnt++;
        end
        bus.freeze = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(st);
            if (!st) break;
            cnt++;
        end
        check("freeze_stall_cycles", 32'(cnt), 32'(9 - RDY_MAX));
        run_idle(4);

        // Flush on a stalled and on an unstalled instruction: neither loads.
        put_write(0, 9, 5); cycle(st);
        put_write(0, 10, 3); bus.use_rs1_d = 1; bus.rs1_d = IDX_W'(9); bus.flush_d = 1; cycle(st);
        put_write(0, 11, 3); bus.flush_d = 1; cycle(st);
        run_idle(8);

        // Reset in the middle of three pending writes.
        put_write(0, 1, 8); cycle(st);
        put_write(0, 2, 7); cycle(st);
        put_write(1, 3, 6); cycle(st);
        idle(); bus.valid_d = 1; bus.use_rs1_d = 1; bus.rs1_d = IDX_W'(1);
        pulse_reset();
        run_idle(2);

        // Random traffic over a small register window to provoke collisions.
        for (int k = 0; k < 3000; k++) begin
            bus.valid_d   = ($urandom_range(0, 9) < 8);
            bus.flush_d   = ($urandom_range(0, 9) == 0);
            bus.freeze    = ($urandom_range(0, 7) == 0);
            bus.rs1_d     = IDX_W'($urandom_range(0, 5));
            bus.rs2_d     = IDX_W'($urandom_range(0, 5));
            bus.rs3_d     = IDX_W'($urandom_range(0, 5));
            bus.use_rs1_d = 1'($urandom);
            bus.use_rs2_d = 1'($urandom);
            bus.use_rs3_d = ($urandom_range(0, 3) == 0);
            bus.fp_rs1_d  = 1'($urandom);
            bus.fp_rs2_d  = 1'($urandom);
            bus.fp_rs3_d  = 1'($urandom);
            bus.rd_d      = IDX_W'($urandom_range(0, 5));
            bus.fp_rd_d   = 1'($urandom);
            bus.wr_lat_d  = LAT_W'($urandom_range(0, (1 << LAT_W) - 1));
            if ($urandom_range(0, 399) == 0) pulse_reset();
            else cycle(st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
